// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-by-word memory copy DMA.
// Each word is read, buffered, then written before the next read.
module mem_copy_engine #(
    parameter int ADDR_BITS = 6,
    parameter int MAX_LEN   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] src_addr,
    input  logic [31:0] dst_addr,
    input  logic [6:0]  length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_writeenable,
    output logic        mem_MemRead,
    input  logic [31:0] mem_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [31:0] LP_MASK =
        32'((64'd1 << ADDR_BITS) - 64'd1);
    localparam logic [7:0]  LP_MAX  = 8'(MAX_LEN);

    state_t      r_state;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [6:0]  r_len;
    logic [6:0]  r_cnt;
    logic [31:0] r_buf;
    logic [31:0] r_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_rd;
    logic        r_we;

    logic        w_len_bad;
    logic        w_len_zero;
    logic [6:0]  w_cnt_next;
    logic        w_more;

    // Word address wraps inside the decoded window; upper bits stay 0.
    function automatic logic [31:0] f_addr(
        input logic [31:0] base,
        input logic [6:0]  off
    );
        return (base + {25'd0, off}) & LP_MASK;
    endfunction

    assign w_len_bad  = ({1'b0, length} > LP_MAX);
    assign w_len_zero = (length == 7'd0);
    assign w_cnt_next = r_cnt + 7'd1;
    assign w_more     = (w_cnt_next < r_len);

    assign busy            = r_busy;
    assign done            = r_done;
    assign error           = r_err;
    assign mem_address     = r_addr;
    assign mem_MemRead     = r_rd;
    assign mem_writeenable = r_we;
    assign mem_writedata   = r_we ? r_buf : 32'd0;

    // Copy sequencer; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rd    <= 1'b0;
            r_we    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src <= src_addr;
                        r_dst <= dst_addr;
                        r_len <= length;
                        r_cnt <= '0;
                        if (w_len_zero || w_len_bad) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_err   <= w_len_bad;
                        end else begin
                            r_state <= S_READ;
                            r_busy  <= 1'b1;
                            r_rd    <= 1'b1;
                            r_addr  <= f_addr(src_addr, 7'd0);
                        end
                    end
                end
                S_READ: begin
                    r_state <= S_WAIT;
                    r_rd    <= 1'b0;
                    r_addr  <= '0;
                end
                S_WAIT: begin
                    r_state <= S_WRITE;
                    r_buf   <= mem_data;
                    r_we    <= 1'b1;
                    r_addr  <= f_addr(r_dst, r_cnt);
                end
                S_WRITE: begin
                    r_we   <= 1'b0;
                    r_addr <= '0;
                    r_cnt  <= w_cnt_next;
                    if (w_more) begin
                        r_state <= S_READ;
                        r_rd    <= 1'b1;
                        r_addr  <= f_addr(r_src, w_cnt_next);
                    end else begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: scoreboard bench with a word-level copy model.
// Expected memory traffic is queued at issue time; a monitor pops it.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [6:0]  length;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic        mem_writeenable;
    logic        mem_MemRead;
    logic [31:0] mem_data = 32'd0;

    always #5 clk = ~clk;

    mem_copy_engine #(
        .ADDR_BITS(6),
        .MAX_LEN  (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_writeenable(mem_writeenable),
        .mem_MemRead    (mem_MemRead),
        .mem_data       (mem_data)
    );

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
        int          cyc;
        bit          err;
        int          nbusy;
    } ev_t;

    ev_t         sb[$];
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int          cyc      = 0;
    int          n_pass   = 0;
    int          n_total  = 0;
    int          busy_cnt = 0;
    int          last_c   = 0;
    ev_t         mon_e;
    int          mon_kind;
    bit          inv_ok;
    logic [31:0] saved;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: samples address and strobes on the falling edge.
    always @(negedge clk) begin
        if (mem_MemRead)
            mem_data = mem[mem_address[5:0]];
        if (mem_writeenable)
            mem[mem_address[5:0]] = mem_writedata;
    end

    task automatic chk(input string name, input bit ok,
                       input logic [31:0] act,
                       input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h",
                      name, act, req);
    endtask

    // Word-level reference: copy i reads (s+i)%64 then writes
    // (d+i)%64; events after 'lim' are dropped (reset abort).
    task automatic model(input logic [31:0] s,
                         input logic [31:0] d,
                         input int l, input int c,
                         input int lim);
        ev_t e;
        int  a;
        int  b;
        if (l >= 1 && l <= 64) begin
            for (int i = 0; i < l; i++) begin
                a = (int'(s[5:0]) + i) % 64;
                b = (int'(d[5:0]) + i) % 64;
                if (c + 1 + 3 * i <= lim) begin
                    e = '{kind: 0, addr: a, data: 32'd0,
                          cyc: c + 1 + 3 * i, err: 1'b0,
                          nbusy: 0};
                    sb.push_back(e);
                end
                if (c + 3 + 3 * i <= lim) begin
                    e = '{kind: 1, addr: b, data: ref_mem[a],
                          cyc: c + 3 + 3 * i, err: 1'b0,
                          nbusy: 0};
                    sb.push_back(e);
                    ref_mem[b] = ref_mem[a];
                end
            end
            if (c + 1 + 3 * l <= lim) begin
                e = '{kind: 2, addr: 0, data: 32'd0,
                      cyc: c + 1 + 3 * l, err: 1'b0,
                      nbusy: 3 * l};
                sb.push_back(e);
            end
        end else if (c + 1 <= lim) begin
            e = '{kind: 2, addr: 0, data: 32'd0,
                  cyc: c + 1, err: (l > 64), nbusy: 0};
            sb.push_back(e);
        end
    endtask

    // Monitor: per-cycle invariants plus in-order event matching.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy) busy_cnt++;
            inv_ok = !(mem_MemRead && mem_writeenable)
                  && (mem_address[31:6] == 26'd0)
                  && (mem_MemRead || mem_writeenable
                      || mem_address == 32'd0)
                  && (mem_writeenable || mem_writedata == 32'd0)
                  && !(busy && done)
                  && (done || !error);
            chk("invariant", inv_ok,
                {mem_MemRead, mem_writeenable, busy, done,
                 error, mem_address[26:0]}, 32'd0);
            if (mem_MemRead || mem_writeenable || done) begin
                mon_kind = mem_MemRead ? 0 : (mem_writeenable ? 1 : 2);
                if (sb.size() == 0) begin
                    chk("unexpected_event", 1'b0,
                        32'(mon_kind), 32'hffff_ffff);
                end else begin
                    mon_e = sb.pop_front();
                    chk("event_kind", mon_kind == mon_e.kind,
                        32'(mon_kind), 32'(mon_e.kind));
                    chk("event_cycle", cyc == mon_e.cyc,
                        32'(cyc), 32'(mon_e.cyc));
                    if (mon_kind != 2)
                        chk("mem_address",
                            mem_address == 32'(mon_e.addr),
                            mem_address, 32'(mon_e.addr));
                    if (mon_kind == 1)
                        chk("mem_writedata",
                            mem_writedata == mon_e.data,
                            mem_writedata, mon_e.data);
                    if (mon_kind == 2) begin
                        chk("done_error", error == mon_e.err,
                            32'(error), 32'(mon_e.err));
                        chk("busy_cycles", busy_cnt == mon_e.nbusy,
                            32'(busy_cnt), 32'(mon_e.nbusy));
                        busy_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic preload(input int i, input logic [31:0] v);
        mem[i]     = v;
        ref_mem[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) preload(i, $urandom);
    endtask

    task automatic issue(input logic [31:0] s,
                         input logic [31:0] d,
                         input int l, input int abort_rel);
        int c;
        @(negedge clk);
        c = cyc;
        last_c = c;
        model(s, d, l, c,
              (abort_rel > 0) ? c + abort_rel : 32'h3fff_ffff);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        length   = 7'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size() == 0,
            32'(sb.size()), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_image();
        int bad = -1;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== ref_mem[i] && bad < 0) bad = i;
        chk("mem_image", bad < 0,
            (bad < 0) ? 32'd0 : mem[bad],
            (bad < 0) ? 32'd0 : ref_mem[bad]);
    endtask

    task automatic check_quiet(input string name);
        chk(name,
            {busy, done, error, mem_MemRead, mem_writeenable} == 5'd0
            && mem_address == 32'd0 && mem_writedata == 32'd0,
            {busy, done, error, mem_MemRead, mem_writeenable,
             mem_address[26:0]}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = 32'd0;
        dst_addr = 32'd0;
        length   = 7'd0;
        fill_random();
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        rst = 1'b0;
        busy_cnt = 0;

        // basic copy
        for (int i = 0; i < 4; i++) preload(i, 32'hA0 + 32'(i));
        issue(32'd0, 32'd8, 4, 0);
        drain();
        check_image();
        for (int i = 0; i < 4; i++)
            chk("basic_word", mem[8 + i] == 32'hA0 + 32'(i),
                mem[8 + i], 32'hA0 + 32'(i));

        // wrap around the 64-word window
        issue(32'd62, 32'd30, 4, 0);
        drain();
        check_image();

        // zero and illegal lengths
        issue(32'd5, 32'd9, 0, 0);
        drain();
        issue(32'd5, 32'd9, 65, 0);
        drain();
        check_image();

        // overlapping regions, ascending order
        for (int i = 0; i < 4; i++) preload(i, 32'(i + 1));
        issue(32'd0, 32'd1, 3, 0);
        drain();
        check_image();
        for (int i = 1; i < 4; i++)
            chk("overlap_word", mem[i] == 32'd1, mem[i], 32'd1);

        // start while busy is ignored
        issue(32'd16, 32'd40, 4, 0);
        while (cyc != last_c + 2) @(negedge clk);
        start    = 1'b1;
        src_addr = 32'd0;
        dst_addr = 32'd50;
        length   = 7'd5;
        @(negedge clk);
        start = 1'b0;
        drain();
        check_image();

        // reset in the middle of a copy
        fill_random();
        saved = mem[45];
        issue(32'd20, 32'd44, 4, 5);
        while (cyc != last_c + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("abort_quiet");
        rst = 1'b0;
        busy_cnt = 0;
        chk("abort_events_seen", sb.size() == 0,
            32'(sb.size()), 32'd0);
        sb.delete();
        repeat (8) @(negedge clk);
        check_image();
        chk("abort_dst1_kept", mem[45] == saved, mem[45], saved);

        // start coincident with reset is discarded
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        src_addr = 32'd0;
        dst_addr = 32'd10;
        length   = 7'd4;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_start_busy", busy == 1'b0, 32'(busy), 32'd0);
        check_image();

        // randomized requests
        for (int t = 0; t < 25; t++) begin
            if (t % 5 == 0) fill_random();
            issue($urandom, $urandom, $urandom_range(0, 70), 0);
            drain();
            check_image();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 6, giving the word-address width actually decoded by data memory.
REQ-002 The block SHALL have parameter MAX_LEN, default 64, giving the largest legal transfer length in words.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: one-cycle copy request, sampled only in IDLE.
REQ-006 The block SHALL have port src_addr, input, 32: first source word address.
REQ-007 The block SHALL have port dst_addr, input, 32: first destination word address.
REQ-008 The block SHALL have port length, input, 7: number of words to copy.
REQ-009 The block SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-010 The block SHALL have port done, output, 1: one-cycle completion pulse.
REQ-011 The block SHALL have port error, output, 1: valid with done; high when the request was rejected.
REQ-012 The block SHALL have port mem_address, output, 32: address driven to data memory.
REQ-013 The block SHALL have port mem_writedata, output, 32: write data driven to data memory.
REQ-014 The block SHALL have port mem_writeenable, output, 1: memory write strobe.
REQ-015 The block SHALL have port mem_MemRead, output, 1: memory read strobe.
REQ-016 The block SHALL have port mem_data, input, 32: read data returned by data memory.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WAIT, WRITE and FIN.
- IDLE: outputs quiescent.
- On start, latch src_addr, dst_addr and length.
- Clear the word counter.
- Go to FIN if length==0 or length>MAX_LEN, else go to READ.
REQ-018 In READ the block SHALL drive mem_address=src+count and mem_MemRead=1 for exactly one cycle, then go to WAIT.
REQ-019 In WAIT the block SHALL register mem_data into the data buffer.
- Read latency is one cycle after the READ cycle; memory samples on the falling clock edge.
- Then go to WRITE.
REQ-020 In WRITE the block SHALL drive mem_address=dst+count, mem_writedata=buffer and mem_writeenable=1 for exactly one cycle.
- Increment count.
- Go to READ if count+1<length, else go to FIN.
REQ-021 Address arithmetic SHALL be modulo 2^ADDR_BITS.
- Sum computed on the low ADDR_BITS bits, upper mem_address bits driven 0.
- Address 63 increments to 0.
REQ-022 FIN SHALL assert done for exactly one cycle and return to IDLE.
- error=1 only if the latched length>MAX_LEN.
- length==0 completes with error=0.
- No memory access occurs for either case.
REQ-023 mem_MemRead and mem_writeenable SHALL never be high in the same cycle; both are 0 outside READ and WRITE.
REQ-024 mem_address and mem_writedata SHALL be 0 whenever neither strobe is high.
REQ-025 start SHALL be ignored while busy or in FIN; latched parameters SHALL NOT change mid-copy.
REQ-026 Overlapping regions SHALL be copied strictly in ascending word order.
- Each word is read then written before the next word is read.
- No other overlap handling is required.
REQ-027 A transfer of N legal words SHALL take exactly 3N cycles of busy followed by one done cycle.

Reset
REQ-028 While rst=1 at a rising edge, the block SHALL enter IDLE and hold these values:
- busy=0, done=0, error=0.
- mem_MemRead=0, mem_writeenable=0.
- mem_address=0, mem_writedata=0.
- Word counter and data buffer cleared.
REQ-029 Reset asserted mid-copy SHALL abort with no further memory strobes and no done pulse.
REQ-030 A start coincident with rst=1 SHALL be discarded.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Basic copy: preload words 0..3 = A0..A3; start src=0 dst=8 len=4 -> words 8..11 = A0..A3; done at cycle 13 after start; error=0.
- Wrap: src=62 dst=30 len=4 -> reads 62,63,0,1 and writes 30..33 in that order; mem_address[31:6]=0 throughout.
- Zero/illegal length: len=0 -> done next cycle, error=0, no strobes; len=65 -> done, error=1, no strobes.
- Overlap: words 0..3 = 1,2,3,4; src=0 dst=1 len=3 -> words 1..3 = 1,1,1.
- Start during busy: second start with different args at cycle 2 -> ignored; result matches the first request only.
- Reset mid-copy: rst at cycle 5 of a len=4 copy -> strobes 0 from the next cycle; no done; destination words beyond the last completed WRITE unchanged.
